// File: rtl/full_adder.sv
// Single-bit full adder: zero-latency combinational sum/carry, plus a
// registered result stage and a bit-serial mode that keeps the carry in an
// internal register so multi-bit operands can be added LSB-first.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   a, b, cin    operand bits and external carry-in
//   s, cout      combinational sum / carry-out (independent of clk/rst_n/en)
//   en           clock enable for every register
//   ser_mode     1 = registered add takes its carry-in from carry_q
//   clr          synchronous carry clear; marks the current bit as the LSB
//   s_q, cout_q  registered sum / carry-out
//   carry_q      serial carry register
//   valid_q      registered outputs hold a result computed since reset
module full_adder #(
  parameter logic CARRY_INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout,
  input  logic en,
  input  logic ser_mode,
  input  logic clr,
  output logic s_q,
  output logic cout_q,
  output logic carry_q,
  output logic valid_q
);

  logic ci_eff;
  logic ci_reg;
  logic s_nxt;
  logic co_nxt;
  logic s_d;
  logic cout_d;
  logic carry_d;
  logic valid_d;

  // Purely combinational adder on the external carry-in.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

  // Next-state for the registered/serial stage.
  always_comb begin
    s_d     = s_q;
    cout_d  = cout_q;
    carry_d = carry_q;
    valid_d = valid_q;

    ci_eff = ser_mode ? carry_q : cin;
    // A clear in serial mode starts a new word, so the stale carry is replaced.
    ci_reg = (clr && ser_mode) ? CARRY_INIT : ci_eff;
    s_nxt  = a ^ b ^ ci_reg;
    co_nxt = (a & b) | (a & ci_reg) | (b & ci_reg);

    if (en) begin
      s_d     = s_nxt;
      cout_d  = co_nxt;
      valid_d = 1'b1;
      if (clr) begin
        carry_d = CARRY_INIT;
        if (ser_mode) begin
          carry_d = co_nxt;
        end
      end else if (ser_mode) begin
        carry_d = co_nxt;
      end
    end
  end

  // Result and carry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= 1'b0;
      cout_q  <= 1'b0;
      carry_q <= CARRY_INIT;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      cout_q  <= cout_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_full_adder.sv
module tb_full_adder;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic rst_n, a, b, cin, en, ser_mode, clr;
  logic s, cout, s_q, cout_q, carry_q, valid_q;

  int checks = 0;
  int errors = 0;

  full_adder #(.CARRY_INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .s(s), .cout(cout),
    .en(en), .ser_mode(ser_mode), .clr(clr), .s_q(s_q), .cout_q(cout_q),
    .carry_q(carry_q), .valid_q(valid_q)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  typedef struct {
    logic a, b, cin;
    logic s, cout;
  } comb_vec_t;

  typedef struct {
    logic en, ser, clr, a, b, cin;
    logic s_q, cout_q, carry_q, valid_q;
  } seq_vec_t;

  comb_vec_t cv[8];
  seq_vec_t  sv[14];

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    // Truth table, index = {a,b,cin}
    cv[0] = '{0,0,0, 0,0};
    cv[1] = '{0,0,1, 1,0};
    cv[2] = '{0,1,0, 1,0};
    cv[3] = '{0,1,1, 0,1};
    cv[4] = '{1,0,0, 1,0};
    cv[5] = '{1,0,1, 0,1};
    cv[6] = '{1,1,0, 0,1};
    cv[7] = '{1,1,1, 1,1};

    //        en ser clr a b cin | s_q co_q carry valid
    sv[0]  = '{1, 0, 0, 1, 1, 0,   0, 1, 0, 1};  // registered 1+1
    sv[1]  = '{0, 0, 0, 0, 0, 1,   0, 1, 0, 1};  // en=0 holds
    sv[2]  = '{1, 1, 1, 1, 0, 0,   1, 0, 0, 1};  // serial 1011+0110 bit0
    sv[3]  = '{1, 1, 0, 1, 1, 0,   0, 1, 1, 1};  // bit1
    sv[4]  = '{1, 1, 0, 0, 1, 0,   0, 1, 1, 1};  // bit2
    sv[5]  = '{1, 1, 0, 1, 0, 0,   0, 1, 1, 1};  // bit3, final carry 1
    sv[6]  = '{1, 1, 1, 0, 0, 0,   0, 0, 0, 1};  // clear mid-op
    sv[7]  = '{1, 1, 1, 1, 1, 0,   0, 1, 1, 1};  // serial 1+1 bit0
    sv[8]  = '{1, 1, 0, 1, 1, 0,   1, 1, 1, 1};  // bit1
    sv[9]  = '{0, 1, 1, 0, 0, 0,   1, 1, 1, 1};  // clr with en=0 ignored
    sv[10] = '{1, 0, 0, 0, 0, 1,   1, 0, 1, 1};  // parallel: carry holds
    sv[11] = '{1, 1, 0, 0, 0, 0,   1, 0, 0, 1};  // back to serial, ci=carry
    sv[12] = '{1, 1, 0, 1, 1, 0,   0, 1, 1, 1};
    sv[13] = '{1, 1, 0, 1, 1, 0,   1, 1, 1, 1};  // s_q=1, carry_q=1

    rst_n = 1'b0; en = 1'b0; ser_mode = 1'b0; clr = 1'b0;
    a = 1'b0; b = 1'b0; cin = 1'b0;

    // Combinational sweep, clock stopped: cin toggles every 10 ns
    for (int i = 0; i < 8; i++) begin
      {a, b, cin} = 3'(i);
      #5;
      check($sformatf("comb_s[%0d]", i), s, cv[i].s);
      check($sformatf("comb_cout[%0d]", i), cout, cv[i].cout);
      #5;
    end

    #1;
    check("rst_s_q", s_q, 1'b0);
    check("rst_cout_q", cout_q, 1'b0);
    check("rst_carry_q", carry_q, 1'b0);
    check("rst_valid_q", valid_q, 1'b0);

    clk_run = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      en = sv[i].en; ser_mode = sv[i].ser; clr = sv[i].clr;
      a = sv[i].a; b = sv[i].b; cin = sv[i].cin;
      @(posedge clk);
      #1;
      check($sformatf("seq_s_q[%0d]", i), s_q, sv[i].s_q);
      check($sformatf("seq_cout_q[%0d]", i), cout_q, sv[i].cout_q);
      check($sformatf("seq_carry_q[%0d]", i), carry_q, sv[i].carry_q);
      check($sformatf("seq_valid_q[%0d]", i), valid_q, sv[i].valid_q);
    end

    // Asynchronous reset mid-cycle with s_q=1, carry_q=1
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_s_q", s_q, 1'b0);
    check("arst_cout_q", cout_q, 1'b0);
    check("arst_carry_q", carry_q, 1'b0);
    check("arst_valid_q", valid_q, 1'b0);
    a = 1'b1; b = 1'b0; cin = 1'b1;
    #1;
    check("rst_live_s", s, 1'b0);
    check("rst_live_cout", cout, 1'b1);
    @(posedge clk);
    #1;
    check("rst_hold_valid_q", valid_q, 1'b0);

    // Release reset; serial add restarts from the initial carry
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1; ser_mode = 1'b1; clr = 1'b0; a = 1'b1; b = 1'b0; cin = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_s_q", s_q, 1'b1);
    check("post_rst_cout_q", cout_q, 1'b0);
    check("post_rst_carry_q", carry_q, 1'b0);
    check("post_rst_valid_q", valid_q, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
